// File: rtl/opc_history_reader_pkg.sv
// Shared definitions for the old-PC history reader.
//   rd_state_t : read-handshake FSM states
//   clog2      : ceiling log2, used to size pointers and counters
package opc_history_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    ACK  = 2'd2
  } rd_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/opc_history_ram.sv
// DEPTH x PCW history storage: one write port, one registered read port.
//   clk, reset_n : clock, async active-low reset (clears the read register only)
//   we, waddr, wdata : write port
//   re, raddr        : read strobe/address; rdata updates on the edge where re=1
//   rdata            : registered read data, holds while re=0
module opc_history_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PCW   = 14,
  parameter int unsigned IW    = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           we,
  input  logic [IW-1:0]  waddr,
  input  logic [PCW-1:0] wdata,
  input  logic           re,
  input  logic [IW-1:0]  raddr,
  output logic [PCW-1:0] rdata
);

  logic [PCW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read and write on the same edge return the pre-write contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rdata <= '0;
    else if (re)   rdata <= mem[raddr];
  end

endmodule

// File: rtl/opc_history_reader.sv
// Captures committed old-PC values into a ring buffer and returns them
// newest-first over a four-phase rd_req/rd_ack handshake.
//   clk, reset_n        : clock, async active-low reset
//   opc, opc_cap        : old-PC value and its one-cycle load strobe
//   freeze              : while high, captures are ignored
//   rd_req, rd_rewind   : read request (level), restart at newest (pulse)
//   rd_ack              : read acknowledge (level)
//   rd_data, rd_empty   : result of the last completed read
//   count               : valid entries, saturating at DEPTH
module opc_history_reader
  import opc_history_reader_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PCW   = 14
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [PCW-1:0]            opc,
  input  logic                      opc_cap,
  input  logic                      freeze,
  input  logic                      rd_req,
  input  logic                      rd_rewind,
  output logic                      rd_ack,
  output logic [PCW-1:0]            rd_data,
  output logic                      rd_empty,
  output logic [clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned IW = clog2(DEPTH);
  localparam int unsigned CW = clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  rd_state_t      state;
  logic [IW-1:0]  wptr;
  logic [CW-1:0]  rd_idx;
  logic [IW-1:0]  rd_addr;
  logic           cap;
  logic           hit;
  logic           empty_q;
  logic [PCW-1:0] ram_q;

  assign cap     = opc_cap & ~freeze;
  // DEPTH is a power of two, so the modulo is plain truncation.
  assign rd_addr = wptr - IW'(1) - rd_idx[IW-1:0];
  assign hit     = (rd_idx < count);

  opc_history_ram #(
    .DEPTH (DEPTH),
    .PCW   (PCW),
    .IW    (IW)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (cap),
    .waddr   (wptr),
    .wdata   (opc),
    .re      (state == READ),
    .raddr   (rd_addr),
    .rdata   (ram_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      count <= '0;
    end else if (cap) begin
      wptr <= wptr + IW'(1);
      if (count != FULL) count <= count + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      rd_idx  <= '0;
      empty_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (rd_req) state <= READ;
        READ: begin
          empty_q <= ~hit;
          state   <= ACK;
        end
        ACK:  if (!rd_req) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (rd_rewind)
        rd_idx <= '0;
      else if (state == ACK && !rd_req && rd_idx != FULL)
        rd_idx <= rd_idx + CW'(1);
    end
  end

  // The RAM read register loads on every READ; an out-of-range read is
  // presented as zero by masking with the registered empty flag.
  assign rd_ack   = (state == ACK);
  assign rd_empty = empty_q;
  assign rd_data  = empty_q ? '0 : ram_q;

endmodule

// File: tb/tb_opc_history_reader.sv
module tb_opc_history_reader;

  localparam int DEPTH = 8;
  localparam int PCW   = 14;
  localparam int CW    = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [PCW-1:0] opc;
  logic           opc_cap;
  logic           freeze;
  logic           rd_req;
  logic           rd_rewind;
  logic           rd_ack;
  logic [PCW-1:0] rd_data;
  logic           rd_empty;
  logic [CW-1:0]  count;

  int total = 0;
  int bad   = 0;

  // Reference model: newest entry at index 0, read age pointer.
  logic [PCW-1:0] hist[$];
  int             midx = 0;

  always #5 clk = ~clk;

  opc_history_reader #(.DEPTH(DEPTH), .PCW(PCW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .opc       (opc),
    .opc_cap   (opc_cap),
    .freeze    (freeze),
    .rd_req    (rd_req),
    .rd_rewind (rd_rewind),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .rd_empty  (rd_empty),
    .count     (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [PCW-1:0] v);
    hist.push_front(v);
    if (hist.size() > DEPTH) void'(hist.pop_back());
  endtask

  task automatic capture(input logic [PCW-1:0] v, input bit frz);
    opc = v; opc_cap = 1'b1; freeze = frz;
    @(negedge clk);
    opc_cap = 1'b0; freeze = 1'b0;
    if (!frz) model_push(v);
  endtask

  task automatic wait_ack(input logic lvl);
    int n = 0;
    while (rd_ack !== lvl && n < 10) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_read(input string tag, input bit rewind_end);
    logic [PCW-1:0] ed;
    logic           ee;
    ee = (midx >= hist.size());
    ed = ee ? '0 : hist[midx];
    rd_req = 1'b1;
    @(negedge clk);
    wait_ack(1'b1);
    chk({tag, " ack"}, rd_ack, 1);
    chk({tag, " data"}, rd_data, ed);
    chk({tag, " empty"}, rd_empty, ee);
    rd_req = 1'b0;
    rd_rewind = rewind_end;
    @(negedge clk);
    rd_rewind = 1'b0;
    chk({tag, " ackfall"}, rd_ack, 0);
    midx = rewind_end ? 0 : ((midx + 1 > DEPTH) ? DEPTH : midx + 1);
  endtask

  task automatic rewind();
    rd_rewind = 1'b1;
    @(negedge clk);
    rd_rewind = 1'b0;
    midx = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    hist.delete();
    midx = 0;
  endtask

  initial begin
    logic [PCW-1:0] ed;
    opc = '0; opc_cap = 0; freeze = 0; rd_req = 0; rd_rewind = 0;
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst ack", rd_ack, 0);
    chk("rst data", rd_data, 0);
    chk("rst empty", rd_empty, 0);
    chk("rst count", count, 0);
    reset_n = 1'b1;

    // Three captures, read past the end.
    capture(14'h0010, 0); capture(14'h0011, 0); capture(14'h0012, 0);
    chk("t1 count", count, 3);
    for (int i = 0; i < 4; i++) do_read("t1 rd", 0);
    chk("t1 sat empty", rd_empty, 1);

    // Capture lands on the READ cycle: read sees the old newest.
    rewind();
    ed = hist[0];
    rd_req = 1'b1;
    @(negedge clk);
    opc = 14'h0200; opc_cap = 1'b1;
    @(negedge clk);
    opc_cap = 1'b0;
    model_push(14'h0200);
    wait_ack(1'b1);
    chk("t4 old newest", rd_data, ed);
    chk("t4 lit", ed, 14'h0012);
    rd_req = 1'b0;
    @(negedge clk);
    midx++;
    rewind();
    do_read("t4 new", 0);
    chk("t4 got 200", rd_data, 14'h0200);

    // Rewind coincident with ACK->IDLE.
    do_read("t5 a", 0);
    do_read("t5 b", 1);
    do_read("t5 age0", 0);

    // Frozen captures are dropped.
    capture(14'h3FFF, 1); capture(14'h3FFF, 1);
    capture(14'h3FFF, 1); capture(14'h3FFF, 1);
    chk("frz count", count, hist.size());
    rewind();
    for (int i = 0; i < 5; i++) begin
      do_read("frz rd", 0);
      total++;
      assert (rd_data !== 14'h3FFF) else begin
        bad++;
        $error("FAIL frz val: got %0h expected not 3fff", rd_data);
      end
    end

    // Wrap: 10 captures into an 8-deep ring.
    do_reset();
    for (int i = 0; i < 10; i++) capture(14'h0100 + PCW'(i), 0);
    chk("wrap count", count, 8);
    for (int i = 0; i < 9; i++) do_read("wrap rd", 0);
    chk("wrap 9th empty", rd_empty, 1);

    // Randomized mix of captures, reads and rewinds.
    for (int i = 0; i < 80; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5)       capture(PCW'($urandom), ($urandom_range(0, 3) == 0));
      else if (r < 9)  do_read("rnd rd", 0);
      else             rewind();
      chk("rnd count", count, hist.size());
    end

    // Async reset in the middle of a handshake.
    rd_req = 1'b1;
    @(negedge clk);
    wait_ack(1'b1);
    chk("mid ack hi", rd_ack, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid ack lo", rd_ack, 0);
    chk("mid count", count, 0);
    chk("mid data", rd_data, 0);
    rd_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    hist.delete();
    midx = 0;
    do_read("post rst", 0);
    chk("post rst empty", rd_empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
